mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one sram-like memory bus between the IF-stage instruction port and the MEM-stage data port.
- Sequences exactly one outstanding transaction at a time: address phase, then data phase, then a one-cycle response.
- Raises stall_for_bus to the pipeline controller while any request is unfinished.
- Ties between the two ports are broken round-robin.

Parameters:
- AW, 32, address width of both ports and the bus
- DW, 32, data width of both ports and the bus

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- inst_req  in  1  instruction read request; level, held until inst_ok
- inst_addr  in  AW  instruction address; stable while inst_req is high
- inst_rdata  out  DW  fetched instruction; valid while inst_ok is high, held afterwards
- inst_ok  out  1  one-cycle completion pulse for the instruction port
- data_req  in  1  data request; level, held until data_ok
- data_wr  in  1  1 = write, 0 = read
- data_wstrb  in  DW/8  byte enables for writes
- data_addr  in  AW  data address
- data_wdata  in  DW  write data
- data_rdata  out  DW  load data; valid while data_ok is high, held afterwards
- data_ok  out  1  one-cycle completion pulse for the data port
- bus_req  out  1  bus address-phase request
- bus_wr  out  1  bus write flag
- bus_wstrb  out  DW/8  bus byte enables
- bus_addr  out  AW  bus address
- bus_wdata  out  DW  bus write data
- bus_addr_ok  in  1  bus accepts the address phase
- bus_data_ok  in  1  bus completes the data phase
- bus_rdata  in  DW  bus read data; valid with bus_data_ok
- stall_for_bus  out  1  pipeline stall request

Behaviour:
- States: IDLE, ADDR, DATA, RESP. A one-bit owner register (INST/DATA) and a last_grant register are kept alongside the state.
- Reset (rst high at a clock edge, including mid-transaction):
  - state = IDLE, owner = INST, last_grant = INST.
  - All latched request fields = 0; inst_rdata = data_rdata = 0.
  - inst_ok = data_ok = 0; bus_req = 0.
  - Any in-flight bus transaction is abandoned; the bus slave is reset by the same rst.
- IDLE:
  - If only one port requests, that port is granted.
  - If both request, the port not equal to last_grant is granted. After reset, data therefore wins the first tie.
  - On grant: latch wr, wstrb, addr and wdata from the granted port; inst grants latch wr = 0 and wstrb = 0. Set owner and last_grant; go to ADDR.
  - If there is no request, stay in IDLE.
- ADDR:
  - bus_req = 1; bus_wr, bus_wstrb, bus_addr and bus_wdata come from the latched registers.
  - bus_addr_ok = 1 moves to DATA; otherwise stay in ADDR.
- DATA:
  - bus_req = 0.
  - bus_data_ok = 1: capture bus_rdata into the owner's rdata register (data-port writes leave data_rdata unchanged), then go to RESP.
- RESP:
  - The owner's ok output is 1 for exactly this cycle; next state is IDLE.
  - The requester must drop req in the cycle after ok, so IDLE never re-grants a completed request.
- Outputs that are registered vs. derived from state:
  - bus_req, bus_wr, bus_wstrb, bus_addr and bus_wdata are driven from state and latched registers.
  - bus_wr, bus_wstrb, bus_addr and bus_wdata are 0 outside ADDR.
  - inst_ok = (state == RESP && owner == INST); data_ok = (state == RESP && owner == DATA).
- stall_for_bus = (inst_req & ~inst_ok) | (data_req & ~data_ok). It is combinational, and is 0 in the RESP cycle when only the owner was requesting.
- Latency:
  - Request seen in IDLE at cycle t gives bus_req at t+1.
  - With bus_addr_ok at t+1 and bus_data_ok at t+2, ok is high at t+3 (3-cycle minimum).
  - Each cycle of bus wait adds exactly one cycle.
- Edge cases:
  - bus_data_ok in ADDR is ignored.
  - bus_addr_ok in DATA/RESP/IDLE is ignored.
  - A request from the other port arriving mid-transaction waits until IDLE.
  - Port inputs that change after grant do not affect the bus.

Test Plan:
- Single inst read, inst_addr=0xBFC00000, bus_addr_ok same cycle, bus_data_ok next cycle with rdata=0x24080001 -> bus_req high exactly 1 cycle with bus_addr=0xBFC00000 and bus_wr=0; inst_ok high at t+3 for 1 cycle; inst_rdata=0x24080001; stall_for_bus high t..t+2, low at t+3.
- Data write, addr=0x80000010, wdata=0xDEADBEEF, wstrb=0xF, bus_addr_ok delayed 2 cycles -> bus_req held 3 cycles with stable bus fields; data_ok one pulse; data_rdata unchanged.
- Both ports request in the same cycle right after reset -> data granted first. On completion with both still pending (inst still high, new data request), inst is granted next. A third tie grants data (alternation).
- Inst transaction in DATA state when data_req rises -> inst completes undisturbed; data granted in the following IDLE; stall_for_bus stays high throughout for the data port.
- rst asserted while in DATA -> next cycle state IDLE, bus_req=0, both ok=0, both rdata=0. The first tie after reset grants data.
- Late spurious bus_data_ok while in ADDR -> ignored; the transaction completes only after bus_addr_ok followed by bus_data_ok.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Shares one sram-like bus between the instruction fetch port and the data port.
// One transaction at a time: address phase, data phase, one-cycle response; ties alternate.
module mem_bus_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inst_req,
    input  logic [AW-1:0]   inst_addr,
    output logic [DW-1:0]   inst_rdata,
    output logic            inst_ok,
    input  logic            data_req,
    input  logic            data_wr,
    input  logic [DW/8-1:0] data_wstrb,
    input  logic [AW-1:0]   data_addr,
    input  logic [DW-1:0]   data_wdata,
    output logic [DW-1:0]   data_rdata,
    output logic            data_ok,
    output logic            bus_req,
    output logic            bus_wr,
    output logic [DW/8-1:0] bus_wstrb,
    output logic [AW-1:0]   bus_addr,
    output logic [DW-1:0]   bus_wdata,
    input  logic            bus_addr_ok,
    input  logic            bus_data_ok,
    input  logic [DW-1:0]   bus_rdata,
    output logic            stall_for_bus
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    state_t          state_reg, state_next;
    logic            owner_reg, owner_next;
    logic            last_grant_reg, last_grant_next;
    logic            wr_reg, wr_next;
    logic [DW/8-1:0] wstrb_reg, wstrb_next;
    logic [AW-1:0]   addr_reg, addr_next;
    logic [DW-1:0]   wdata_reg, wdata_next;
    logic [DW-1:0]   inst_rdata_reg, inst_rdata_next;
    logic [DW-1:0]   data_rdata_reg, data_rdata_next;
    logic            grant_valid;
    logic            grant_port;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            owner_reg      <= OWN_INST;
            last_grant_reg <= OWN_INST;
            wr_reg         <= 1'b0;
            wstrb_reg      <= '0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            inst_rdata_reg <= '0;
            data_rdata_reg <= '0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_grant_reg <= last_grant_next;
            wr_reg         <= wr_next;
            wstrb_reg      <= wstrb_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            inst_rdata_reg <= inst_rdata_next;
            data_rdata_reg <= data_rdata_next;
        end
    end

    // On a tie the port that did not win last time gets the bus.
    always_comb begin
        grant_valid = inst_req | data_req;
        if (inst_req && data_req)
            grant_port = (last_grant_reg == OWN_INST) ? OWN_DATA : OWN_INST;
        else if (data_req)
            grant_port = OWN_DATA;
        else
            grant_port = OWN_INST;
    end

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_grant_next = last_grant_reg;
        wr_next         = wr_reg;
        wstrb_next      = wstrb_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        inst_rdata_next = inst_rdata_reg;
        data_rdata_next = data_rdata_reg;
        case (state_reg)
            S_IDLE: begin
                if (grant_valid) begin
                    owner_next      = grant_port;
                    last_grant_next = grant_port;
                    state_next      = S_ADDR;
                    if (grant_port == OWN_DATA) begin
                        wr_next    = data_wr;
                        wstrb_next = data_wstrb;
                        addr_next  = data_addr;
                        wdata_next = data_wdata;
                    end else begin
                        wr_next    = 1'b0;
                        wstrb_next = '0;
                        addr_next  = inst_addr;
                        wdata_next = '0;
                    end
                end
            end
            S_ADDR: begin
                if (bus_addr_ok)
                    state_next = S_DATA;
            end
            S_DATA: begin
                if (bus_data_ok) begin
                    state_next = S_RESP;
                    if (owner_reg == OWN_INST)
                        inst_rdata_next = bus_rdata;
                    else if (!wr_reg)
                        data_rdata_next = bus_rdata;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign bus_req    = (state_reg == S_ADDR);
    assign bus_wr     = bus_req & wr_reg;
    assign bus_wstrb  = bus_req ? wstrb_reg : '0;
    assign bus_addr   = bus_req ? addr_reg  : '0;
    assign bus_wdata  = bus_req ? wdata_reg : '0;

    assign inst_ok    = (state_reg == S_RESP) && (owner_reg == OWN_INST);
    assign data_ok    = (state_reg == S_RESP) && (owner_reg == OWN_DATA);
    assign inst_rdata = inst_rdata_reg;
    assign data_rdata = data_rdata_reg;

    assign stall_for_bus = (inst_req & ~inst_ok) | (data_req & ~data_ok);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: the bench plays the bus slave cycle by cycle.
module tb_mem_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_ok;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_ok;
    logic        bus_req;
    logic        bus_wr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;
    logic        stall_for_bus;

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [31:0] R_TIE1 = 32'h1111_0001;
    localparam logic [31:0] R_TIE2 = 32'h2222_0002;
    localparam logic [31:0] R_TIE3 = 32'h3333_0003;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ok(inst_ok),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_ok(data_ok),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
        .bus_rdata(bus_rdata), .stall_for_bus(stall_for_bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0; data_wstrb = 0;
        data_addr = 0; data_wdata = 0; bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
        step(); step();
        tests_run++; if (bus_req !== 1'b0) begin tests_failed++; $display("FAIL reset_bus_req got=%0b exp=0", bus_req); end
        tests_run++; if ({inst_ok, data_ok} !== 2'b00) begin tests_failed++; $display("FAIL reset_ok got=%b exp=00", {inst_ok, data_ok}); end
        tests_run++; if (inst_rdata !== 32'h0 || data_rdata !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata got=%h/%h exp=0/0", inst_rdata, data_rdata); end
        tests_run++; if (bus_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_bus_addr got=%h exp=0", bus_addr); end
        rst = 1'b0;
        $display("[TB] test_reset done");
    endtask

    task automatic test_tie_alternation();
        inst_req = 1; inst_addr = 32'hBFC0_0100;
        data_req = 1; data_wr = 0; data_addr = 32'h8000_0100;
        step();
        tests_run++; if (bus_addr !== 32'h8000_0100) begin tests_failed++; $display("FAIL tie1_grant got=%h exp=80000100", bus_addr); end
        bus_addr_ok = 1; step();
        bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = R_TIE1; step();
        bus_data_ok = 0;
        tests_run++; if ({inst_ok, data_ok} !== 2'b01) begin tests_failed++; $display("FAIL tie1_ok got=%b exp=01", {inst_ok, data_ok}); end
        tests_run++; if (stall_for_bus !== 1'b1) begin tests_failed++; $display("FAIL tie1_stall got=%0b exp=1", stall_for_bus); end
        tests_run++; if (data_rdata !== R_TIE1) begin tests_failed++; $display("FAIL tie1_rdata got=%h exp=%h", data_rdata, R_TIE1); end
        data_addr = 32'h8000_0200;
        step();
        step();
        tests_run++; if (bus_addr !== 32'hBFC0_0100) begin tests_failed++; $display("FAIL tie2_grant got=%h exp=bfc00100", bus_addr); end
        bus_addr_ok = 1; step();
        bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = R_TIE2; step();
        bus_data_ok = 0;
        tests_run++; if ({inst_ok, data_ok} !== 2'b10) begin tests_failed++; $display("FAIL tie2_ok got=%b exp=10", {inst_ok, data_ok}); end
        tests_run++; if (inst_rdata !== R_TIE2) begin tests_failed++; $display("FAIL tie2_rdata got=%h exp=%h", inst_rdata, R_TIE2); end
        inst_addr = 32'hBFC0_0104;
        step();
        step();
        tests_run++; if (bus_addr !== 32'h8000_0200) begin tests_failed++; $display("FAIL tie3_grant got=%h exp=80000200", bus_addr); end
        bus_addr_ok = 1; step();
        bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = R_TIE3; step();
        bus_data_ok = 0;
        tests_run++; if (data_rdata !== R_TIE3) begin tests_failed++; $display("FAIL tie3_rdata got=%h exp=%h", data_rdata, R_TIE3); end
        step();
        inst_req = 0; data_req = 0;
        step();
        $display("[TB] test_tie_alternation done");
    endtask

    task automatic test_single_inst();
        inst_req = 1; inst_addr = 32'hBFC0_0000;
        #1;
        tests_run++; if (stall_for_bus !== 1'b1) begin tests_failed++; $display("FAIL inst_stall_t got=%0b exp=1", stall_for_bus); end
        step();
        tests_run++; if (bus_req !== 1'b1 || bus_addr !== 32'hBFC0_0000 || bus_wr !== 1'b0) begin tests_failed++; $display("FAIL inst_addr_phase got req=%0b addr=%h wr=%0b exp 1/bfc00000/0", bus_req, bus_addr, bus_wr); end
        bus_addr_ok = 1; step();
        bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h2408_0001;
        tests_run++; if (bus_req !== 1'b0 || inst_ok !== 1'b0 || stall_for_bus !== 1'b1) begin tests_failed++; $display("FAIL inst_data_phase got req=%0b ok=%0b stall=%0b exp 0/0/1", bus_req, inst_ok, stall_for_bus); end
        step();
        bus_data_ok = 0; bus_rdata = 32'hFFFF_FFFF;
        tests_run++; if (inst_ok !== 1'b1 || inst_rdata !== 32'h2408_0001) begin tests_failed++; $display("FAIL inst_resp got ok=%0b rdata=%h exp 1/24080001", inst_ok, inst_rdata); end
        tests_run++; if (stall_for_bus !== 1'b0) begin tests_failed++; $display("FAIL inst_resp_stall got=%0b exp=0", stall_for_bus); end
        step();
        inst_req = 0;
        tests_run++; if (inst_ok !== 1'b0 || inst_rdata !== 32'h2408_0001) begin tests_failed++; $display("FAIL inst_after got ok=%0b rdata=%h exp 0/24080001", inst_ok, inst_rdata); end
        step();
        tests_run++; if (bus_req !== 1'b0) begin tests_failed++; $display("FAIL inst_no_regrant got=%0b exp=0", bus_req); end
        $display("[TB] test_single_inst done");
    endtask

    task automatic test_data_write();
        data_req = 1; data_wr = 1; data_wstrb = 4'hF; data_addr = 32'h8000_0010; data_wdata = 32'hDEAD_BEEF;
        step();
        tests_run++; if ({bus_req, bus_wr, bus_wstrb} !== 6'b11_1111 || bus_addr !== 32'h8000_0010 || bus_wdata !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL wr_addr_phase got req=%0b wr=%0b strb=%h addr=%h wdata=%h", bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata); end
        data_addr = 32'h0; data_wdata = 32'h0;
        step();
        tests_run++; if (bus_req !== 1'b1 || bus_addr !== 32'h8000_0010 || bus_wdata !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL wr_hold1 got req=%0b addr=%h wdata=%h exp 1/80000010/deadbeef", bus_req, bus_addr, bus_wdata); end
        step();
        bus_addr_ok = 1;
        tests_run++; if (bus_req !== 1'b1 || bus_addr !== 32'h8000_0010) begin tests_failed++; $display("FAIL wr_hold2 got req=%0b addr=%h exp 1/80000010", bus_req, bus_addr); end
        step();
        bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h1234_5678;
        tests_run++; if (bus_req !== 1'b0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0 || bus_wr !== 1'b0) begin tests_failed++; $display("FAIL wr_bus_cleared got req=%0b addr=%h wdata=%h wr=%0b exp all 0", bus_req, bus_addr, bus_wdata, bus_wr); end
        step();
        bus_data_ok = 0;
        tests_run++; if ({inst_ok, data_ok} !== 2'b01) begin tests_failed++; $display("FAIL wr_ok got=%b exp=01", {inst_ok, data_ok}); end
        tests_run++; if (data_rdata !== R_TIE3) begin tests_failed++; $display("FAIL wr_rdata_kept got=%h exp=%h", data_rdata, R_TIE3); end
        step();
        data_req = 0; data_wr = 0; data_wstrb = 0;
        tests_run++; if (data_ok !== 1'b0) begin tests_failed++; $display("FAIL wr_ok_pulse got=%0b exp=0", data_ok); end
        step();
        $display("[TB] test_data_write done");
    endtask

    task automatic test_mid_arrival();
        inst_req = 1; inst_addr = 32'hBFC0_0200;
        step();
        bus_addr_ok = 1; step();
        bus_addr_ok = 0; data_req = 1; data_wr = 0; data_addr = 32'h8000_0020;
        tests_run++; if (stall_for_bus !== 1'b1 || bus_req !== 1'b0) begin tests_failed++; $display("FAIL mid_data_wait got stall=%0b req=%0b exp 1/0", stall_for_bus, bus_req); end
        step();
        bus_data_ok = 1; bus_rdata = 32'hCAFE_0200;
        step();
        bus_data_ok = 0;
        tests_run++; if ({inst_ok, data_ok} !== 2'b10 || inst_rdata !== 32'hCAFE_0200) begin tests_failed++; $display("FAIL mid_inst_done got ok=%b rdata=%h exp 10/cafe0200", {inst_ok, data_ok}, inst_rdata); end
        tests_run++; if (stall_for_bus !== 1'b1) begin tests_failed++; $display("FAIL mid_stall_resp got=%0b exp=1", stall_for_bus); end
        step();
        inst_req = 0;
        step();
        tests_run++; if (bus_req !== 1'b1 || bus_addr !== 32'h8000_0020) begin tests_failed++; $display("FAIL mid_data_grant got req=%0b addr=%h exp 1/80000020", bus_req, bus_addr); end
        bus_addr_ok = 1; step();
        bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h55AA_55AA; step();
        bus_data_ok = 0;
        tests_run++; if (data_ok !== 1'b1 || data_rdata !== 32'h55AA_55AA) begin tests_failed++; $display("FAIL mid_data_done got ok=%0b rdata=%h exp 1/55aa55aa", data_ok, data_rdata); end
        step();
        data_req = 0;
        step();
        $display("[TB] test_mid_arrival done");
    endtask

    task automatic test_reset_mid();
        inst_req = 1; inst_addr = 32'hBFC0_0300;
        step();
        bus_addr_ok = 1; step();
        bus_addr_ok = 0; rst = 1;
        step();
        tests_run++; if (bus_req !== 1'b0 || {inst_ok, data_ok} !== 2'b00) begin tests_failed++; $display("FAIL rstmid_ctrl got req=%0b ok=%b exp 0/00", bus_req, {inst_ok, data_ok}); end
        tests_run++; if (inst_rdata !== 32'h0 || data_rdata !== 32'h0) begin tests_failed++; $display("FAIL rstmid_rdata got=%h/%h exp=0/0", inst_rdata, data_rdata); end
        rst = 0; data_req = 1; data_wr = 0; data_addr = 32'h8000_0040;
        step();
        tests_run++; if (bus_req !== 1'b1 || bus_addr !== 32'h8000_0040) begin tests_failed++; $display("FAIL rstmid_tie got req=%0b addr=%h exp 1/80000040", bus_req, bus_addr); end
        bus_addr_ok = 1; step();
        bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h0BAD_F00D; step();
        bus_data_ok = 0;
        tests_run++; if (data_ok !== 1'b1 || data_rdata !== 32'h0BAD_F00D) begin tests_failed++; $display("FAIL rstmid_done got ok=%0b rdata=%h exp 1/0badf00d", data_ok, data_rdata); end
        step();
        inst_req = 0; data_req = 0;
        step();
        $display("[TB] test_reset_mid done");
    endtask

    task automatic test_spurious();
        inst_req = 1; inst_addr = 32'hBFC0_0400;
        step();
        bus_data_ok = 1; bus_rdata = 32'hBAD0_BAD0;
        step();
        bus_data_ok = 0;
        tests_run++; if (bus_req !== 1'b1 || inst_rdata !== 32'h0) begin tests_failed++; $display("FAIL spur_ignored got req=%0b rdata=%h exp 1/0", bus_req, inst_rdata); end
        bus_addr_ok = 1; step();
        step();
        tests_run++; if (bus_req !== 1'b0 || inst_ok !== 1'b0) begin tests_failed++; $display("FAIL spur_addr_in_data got req=%0b ok=%0b exp 0/0", bus_req, inst_ok); end
        bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h0000_0400;
        step();
        bus_data_ok = 0;
        tests_run++; if (inst_ok !== 1'b1 || inst_rdata !== 32'h0000_0400) begin tests_failed++; $display("FAIL spur_done got ok=%0b rdata=%h exp 1/00000400", inst_ok, inst_rdata); end
        step();
        inst_req = 0;
        step();
        $display("[TB] test_spurious done");
    endtask

    initial begin
        test_reset();
        test_tie_alternation();
        test_single_inst();
        test_data_write();
        test_mid_arrival();
        test_reset_mid();
        test_spurious();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
